// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: round-robin sharing of one SPI byte transmitter between
// two requesters. Latches the granted byte, pulses spi_start, follows the
// transmitter chip-select through the frame, inserts an inter-byte gap and
// returns a done pulse to the owning requester.
// Optional build macro: SPI_SCHED_TIMEOUT_EN adds a per-wait-state watchdog
// that raises err together with the owner's done pulse.
module spi_tx_scheduler #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       grant0,
  output logic       done0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       grant1,
  output logic       done1,
  output logic       spi_start,
  output logic [7:0] spi_data,
  input  logic       spi_cs_in,
  output logic       busy,
  output logic       err
);

  localparam int unsigned GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_LAST_I[GAP_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic             owner;
  logic             pick;
  logic [GAP_W-1:0] gap_cnt;
  logic             wd_expire;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

  logic [WD_W-1:0] wd_cnt;

  // Watchdog: restarts on entry to WAIT_LOW and to WAIT_HIGH, counts while waiting
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE || (state == S_WAIT_LOW && !spi_cs_in)) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT_LOW || state == S_WAIT_HIGH) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = (state == S_WAIT_LOW || state == S_WAIT_HIGH) && (wd_cnt == WD_LAST);
`else
  // Watchdog compiled out; the timeout limit has no effect in this build
  assign wd_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Arbitration: a lone request wins, otherwise the port named by rr_ptr
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = rr_ptr;
    else              pick = req1;
  end

  // Scheduler FSM with registered grant/start/done/err pulses and busy level
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= S_IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      gap_cnt   <= '0;
      grant0    <= 1'b0;
      grant1    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      spi_start <= 1'b0;
      spi_data  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      grant0    <= 1'b0;
      grant1    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      spi_start <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            state     <= S_ISSUE;
            busy      <= 1'b1;
            owner     <= pick;
            rr_ptr    <= ~pick;
            grant0    <= ~pick;
            grant1    <= pick;
            spi_start <= 1'b1;
            spi_data  <= pick ? data1 : data0;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!spi_cs_in) begin
            state <= S_WAIT_HIGH;
          end else if (wd_expire) begin
            state <= S_DONE;
            err   <= 1'b1;
            done0 <= ~owner;
            done1 <= owner;
          end
        end
        S_WAIT_HIGH: begin
          if (spi_cs_in) begin
            if (GAP_CYCLES == 0) begin
              state <= S_DONE;
              done0 <= ~owner;
              done1 <= owner;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end else if (wd_expire) begin
            state <= S_DONE;
            err   <= 1'b1;
            done0 <= ~owner;
            done1 <= owner;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_DONE;
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
